// File: rtl/eight_bit_full_subtractor_pkg.sv
// Purpose: shared constants for the 8-bit ripple subtractor slice.
// Contents:
//   DATA_W - operand and difference width used by every file of the slice.
package eight_bit_full_subtractor_pkg;

  localparam int DATA_W = 8;

endpackage

// File: rtl/eight_bit_full_subtractor_cell.sv
// Purpose: one bit of the ripple subtractor chain, purely combinational.
// Ports:
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow in from the next lower bit
//   d    - difference bit
//   bout - borrow out to the next higher bit
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // A borrow leaves this bit when b exceeds a outright, or when the bits
  // are equal and a borrow is already arriving from below.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/eight_bit_full_subtractor.sv
// Purpose: unsigned 8-bit subtractor, diff = (a - b) mod 256, with a
//          borrow flag that doubles as an unsigned a < b indication.
//          One-cycle latency; all outputs come straight from flops.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset, higher priority than in_valid
//   a, b      - unsigned operands
//   in_valid  - qualifies a/b this cycle
//   diff      - registered difference
//   b_out     - registered borrow out of the top bit
//   out_valid - registered copy of in_valid
module eight_bit_full_subtractor
  import eight_bit_full_subtractor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              in_valid,
  output logic [DATA_W-1:0] diff,
  output logic              b_out,
  output logic              out_valid
);

  logic [DATA_W:0]   borrow;
  logic [DATA_W-1:0] diff_d;
  logic [DATA_W-1:0] diff_q;
  logic              b_out_q;
  logic              out_valid_q;

  // The chain starts with no borrow; the final borrow is the a < b flag.
  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < DATA_W; i++) begin : g_cell
    full_subtractor_1bit u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (borrow[i]),
      .d    (diff_d[i]),
      .bout (borrow[i+1])
    );
  end

  // Data registers load every cycle regardless of in_valid; consumers key
  // off out_valid, so gating the data would only add an enable for nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      diff_q      <= '0;
      b_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      diff_q      <= diff_d;
      b_out_q     <= borrow[DATA_W];
      out_valid_q <= in_valid;
    end
  end

  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_eight_bit_full_subtractor.sv
// Purpose: self-checking bench for eight_bit_full_subtractor. Every driven
//          cycle pushes its expected registered result onto a scoreboard,
//          which is popped and compared one edge later.
module tb_eight_bit_full_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       valid;
    logic       rst;
    logic [7:0] expDiff;
    logic       expBout;
    logic       expValid;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       valid;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       inValid = 1'b0;
  logic [7:0] diff;
  logic       bOut;
  logic       outValid;

  exp_t  expQ[$];
  string nameQ[$];
  int    compared = 0;
  int    mismatched = 0;

  vec_t vecs[14];

  eight_bit_full_subtractor dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .in_valid  (inValid),
    .diff      (diff),
    .b_out     (bOut),
    .out_valid (outValid)
  );

  always #5 clk = ~clk;

  // Reference model: widen to 9 bits so the top bit is the borrow.
  function automatic exp_t modelSub(input logic [7:0] av, input logic [7:0] bv,
                                    input logic v, input logic r);
    exp_t e;
    logic [8:0] full;
    full = {1'b0, av} - {1'b0, bv};
    if (r) begin
      e.diff = 8'h00; e.bout = 1'b0; e.valid = 1'b0;
    end else begin
      e.diff = full[7:0]; e.bout = full[8]; e.valid = v;
    end
    return e;
  endfunction

  function automatic vec_t mkVec(input logic [7:0] av, input logic [7:0] bv,
                                 input logic v, input logic r, input logic [7:0] ed,
                                 input logic eb, input logic ev);
    vec_t t;
    t.a = av; t.b = bv; t.valid = v; t.rst = r;
    t.expDiff = ed; t.expBout = eb; t.expValid = ev;
    return t;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue its expectation.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic v, input logic r, input exp_t e,
                               input string nm);
    @(negedge clk);
    a = av; b = bv; inValid = v; reset = r;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic checkOutput(input exp_t e, input string nm);
    compared++;
    if (diff !== e.diff || bOut !== e.bout || outValid !== e.valid) begin
      mismatched++;
      $display("[TB] FAIL %s: got diff=%0d b_out=%b out_valid=%b, expected diff=%0d b_out=%b out_valid=%b",
               nm, diff, bOut, outValid, e.diff, e.bout, e.valid);
    end
  endtask

  // Results land one edge after their operands were sampled.
  always @(posedge clk) begin
    #1;
    if (expQ.size() != 0) begin
      exp_t  e;
      string nm;
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      checkOutput(e, nm);
    end
  end

  function automatic exp_t fromVec(input vec_t t);
    exp_t e;
    e.diff = t.expDiff; e.bout = t.expBout; e.valid = t.expValid;
    return e;
  endfunction

  initial begin
    exp_t e;
    int   waitCycles;

    // Reset hold with hostile operands, borrow sweep from a = 0, edges.
    vecs[0]  = mkVec(8'hFF, 8'h01, 1, 1, 8'd0,   0, 0);
    vecs[1]  = mkVec(8'hFF, 8'h01, 1, 1, 8'd0,   0, 0);
    vecs[2]  = mkVec(8'd0,  8'd255, 1, 0, 8'd1,   1, 1);
    vecs[3]  = mkVec(8'd0,  8'd127, 1, 0, 8'd129, 1, 1);
    vecs[4]  = mkVec(8'd0,  8'd63,  1, 0, 8'd193, 1, 1);
    vecs[5]  = mkVec(8'd0,  8'd31,  1, 0, 8'd225, 1, 1);
    vecs[6]  = mkVec(8'd0,  8'd15,  1, 0, 8'd241, 1, 1);
    vecs[7]  = mkVec(8'd0,  8'd7,   1, 0, 8'd249, 1, 1);
    vecs[8]  = mkVec(8'd0,  8'd3,   1, 0, 8'd253, 1, 1);
    vecs[9]  = mkVec(8'd0,  8'd1,   1, 0, 8'd255, 1, 1);
    vecs[10] = mkVec(8'd0,  8'd0,   1, 0, 8'd0,   0, 1);
    vecs[11] = mkVec(8'd255, 8'd255, 1, 0, 8'd0,   0, 1);
    vecs[12] = mkVec(8'd255, 8'd0,   1, 0, 8'd255, 0, 1);
    vecs[13] = mkVec(8'd0,   8'd1,   1, 0, 8'd255, 1, 1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].valid, vecs[i].rst,
                    fromVec(vecs[i]), $sformatf("vec%0d", i));
    end

    // Valid gating: data keeps updating, out_valid follows in_valid.
    e.diff = 8'd7; e.bout = 1'b0; e.valid = 1'b1;
    applyStimulus(8'd10, 8'd3, 1, 0, e, "gate_v1");
    e.valid = 1'b0;
    applyStimulus(8'd10, 8'd3, 0, 0, e, "gate_v0");
    e.valid = 1'b1;
    applyStimulus(8'd10, 8'd3, 1, 0, e, "gate_v1b");

    // Reset pulse between two valid pairs clears the first result.
    e.diff = 8'd15; e.bout = 1'b0; e.valid = 1'b1;
    applyStimulus(8'd20, 8'd5, 1, 0, e, "mid_pre");
    e.diff = 8'd0; e.bout = 1'b0; e.valid = 1'b0;
    applyStimulus(8'd5, 8'd20, 1, 1, e, "mid_rst");
    e.diff = 8'd241; e.bout = 1'b1; e.valid = 1'b1;
    applyStimulus(8'd5, 8'd20, 1, 0, e, "mid_post");

    // Exhaustive back-to-back sweep against the widened model.
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        applyStimulus(ai[7:0], bi[7:0], 1'b1, 1'b0,
                      modelSub(ai[7:0], bi[7:0], 1'b1, 1'b0), "exh");
      end
    end

    @(negedge clk);
    inValid = 1'b0;
    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d results pending, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
